ts_pair_scheduler: RTL and testbench

Processing sequencer for one bunch crossing in the tracklet seeding path. It is started by the start-new-crossing controller and owns the proc_sm_bsy handshake back to it. It walks every inner x outer stub pair of the crossing, issuing read addresses to both stub memories. It presents aligned pair-valid strobes to the tracklet calculation pipeline and accumulates the per-crossing tracklet count.

---
 rtl/ts_pkg.sv | 20 ++
 rtl/ts_pair_index_cntr.sv | 43 ++++
 rtl/ts_pair_scheduler.sv | 127 ++++++++++++
 tb/tb_ts_pair_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants for the tracklet seeding pair scheduler:
// state indices, read latency and default widths.
package ts_pkg;

    localparam int ADR_W_DEF = 6;
    localparam int CNT_W_DEF = 7;
    localparam int TRK_W_DEF = 12;

    // stub memory read latency, rd_en to data valid
    localparam int RD_LAT = 2;

    // one-hot state bit positions
    localparam int IDLE   = 0;
    localparam int LOAD   = 1;
    localparam int ISSUE  = 2;
    localparam int DRAIN  = 3;
    localparam int DONE   = 4;
    localparam int NUM_ST = 5;

endpackage

// File: rtl/ts_pair_index_cntr.sv
// Nested inner(i) x outer(j) pair index counter.
// Ports: clk, res, ld (zero both), en (advance), inner_cnt/outer_cnt,
// i/j indices, last (i and j both at their final value).
module ts_pair_index_cntr
    import ts_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ld,
    input  logic             en,
    input  logic [CNT_W-1:0] inner_cnt,
    input  logic [CNT_W-1:0] outer_cnt,
    output logic [ADR_W-1:0] i,
    output logic [ADR_W-1:0] j,
    output logic             last
);

    logic i_end;
    logic j_end;

    // compare in CNT_W so a count of 2^ADR_W ends at index 2^ADR_W-1
    assign j_end = CNT_W'(j) == outer_cnt - CNT_W'(1);
    assign i_end = CNT_W'(i) == inner_cnt - CNT_W'(1);
    assign last  = i_end & j_end;

    always_ff @(posedge clk) begin
        if (res || ld) begin
            i <= '0;
            j <= '0;
        end else if (en) begin
            if (j_end) begin
                j <= '0;
                i <= i_end ? '0 : i + ADR_W'(1);
            end else begin
                j <= j + ADR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ts_pair_scheduler.sv
// Per-crossing inner x outer stub pair sequencer with tracklet count.
// Ports: clk, res, start_proc + load enables/bases/counts in; pipe_stall,
// tracklet_found, tracklet_cnt_clr in; read addresses, rd_en, pair_vld,
// last_pair, proc_sm_bsy, proc_done, tracklet_cnt out.
module ts_pair_scheduler
    import ts_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TRK_W = TRK_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start_proc,
    input  logic             stub_adr_ld_en,
    input  logic             stub_cntr_ld_en,
    input  logic [ADR_W-1:0] inner_base,
    input  logic [ADR_W-1:0] outer_base,
    input  logic [CNT_W-1:0] inner_cnt,
    input  logic [CNT_W-1:0] outer_cnt,
    input  logic             pipe_stall,
    input  logic             tracklet_found,
    input  logic             tracklet_cnt_clr,
    output logic [ADR_W-1:0] inner_rd_adr,
    output logic [ADR_W-1:0] outer_rd_adr,
    output logic             rd_en,
    output logic             pair_vld,
    output logic             last_pair,
    output logic             proc_sm_bsy,
    output logic             proc_done,
    output logic [TRK_W-1:0] tracklet_cnt
);

    localparam logic [NUM_ST-1:0] ST_IDLE  = NUM_ST'(1) << IDLE;
    localparam logic [NUM_ST-1:0] ST_LOAD  = NUM_ST'(1) << LOAD;
    localparam logic [NUM_ST-1:0] ST_ISSUE = NUM_ST'(1) << ISSUE;
    localparam logic [NUM_ST-1:0] ST_DRAIN = NUM_ST'(1) << DRAIN;
    localparam logic [NUM_ST-1:0] ST_DONE  = NUM_ST'(1) << DONE;

    logic [NUM_ST-1:0] state;
    logic [NUM_ST-1:0] state_nxt;
    logic [ADR_W-1:0]  inner_base_q;
    logic [ADR_W-1:0]  outer_base_q;
    logic [CNT_W-1:0]  inner_cnt_q;
    logic [CNT_W-1:0]  outer_cnt_q;
    logic [ADR_W-1:0]  idx_i;
    logic [ADR_W-1:0]  idx_j;
    logic              idx_last;
    logic              accept;
    logic              empty;
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;

    assign accept = state[IDLE] & start_proc;
    assign empty  = (inner_cnt_q == '0) | (outer_cnt_q == '0);

    assign rd_en        = state[ISSUE] & ~pipe_stall;
    assign inner_rd_adr = state[ISSUE] ? inner_base_q + idx_i : '0;
    assign outer_rd_adr = state[ISSUE] ? outer_base_q + idx_j : '0;
    assign pair_vld     = vld_sr[RD_LAT-1];
    assign last_pair    = last_sr[RD_LAT-1];
    assign proc_done    = state[DONE];

    ts_pair_index_cntr #(
        .ADR_W(ADR_W),
        .CNT_W(CNT_W)
    ) u_idx (
        .clk      (clk),
        .res      (res),
        .ld       (state[LOAD]),
        .en       (rd_en),
        .inner_cnt(inner_cnt_q),
        .outer_cnt(outer_cnt_q),
        .i        (idx_i),
        .j        (idx_j),
        .last     (idx_last)
    );

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state[IDLE]:  if (start_proc) state_nxt = ST_LOAD;
            state[LOAD]:  state_nxt = empty ? ST_DONE : ST_ISSUE;
            state[ISSUE]: if (rd_en && idx_last) state_nxt = ST_DRAIN;
            // wait for every in-flight read to reach the pipeline
            state[DRAIN]: if (vld_sr == '0) state_nxt = ST_DONE;
            state[DONE]:  state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state        <= ST_IDLE;
            proc_sm_bsy  <= 1'b0;
            inner_base_q <= '0;
            outer_base_q <= '0;
            inner_cnt_q  <= '0;
            outer_cnt_q  <= '0;
            vld_sr       <= '0;
            last_sr      <= '0;
        end else begin
            state       <= state_nxt;
            proc_sm_bsy <= ~state_nxt[IDLE];
            if (accept && stub_adr_ld_en) begin
                inner_base_q <= inner_base;
                outer_base_q <= outer_base;
            end
            if (accept && stub_cntr_ld_en) begin
                inner_cnt_q <= inner_cnt;
                outer_cnt_q <= outer_cnt;
            end
            // not frozen by pipe_stall: issued reads always complete
            vld_sr  <= {vld_sr[RD_LAT-2:0], rd_en};
            last_sr <= {last_sr[RD_LAT-2:0], rd_en & idx_last};
        end
    end

    always_ff @(posedge clk) begin
        if (res || tracklet_cnt_clr) begin
            tracklet_cnt <= '0;
        end else if (tracklet_found && tracklet_cnt != '1) begin
            tracklet_cnt <= tracklet_cnt + TRK_W'(1);
        end
    end

endmodule

// File: tb/tb_ts_pair_scheduler.sv
// Scoreboard bench for ts_pair_scheduler: directed and random crossings
// against a nested-loop pair model, plus tracklet counter model.
module tb_ts_pair_scheduler;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       res;
    logic       start_proc;
    logic       stub_adr_ld_en;
    logic       stub_cntr_ld_en;
    logic [5:0] inner_base;
    logic [5:0] outer_base;
    logic [6:0] inner_cnt;
    logic [6:0] outer_cnt;
    logic       pipe_stall;
    logic       tracklet_found;
    logic       tracklet_cnt_clr;
    logic [5:0] inner_rd_adr;
    logic [5:0] outer_rd_adr;
    logic       rd_en;
    logic       pair_vld;
    logic       last_pair;
    logic       proc_sm_bsy;
    logic       proc_done;
    logic [11:0] tracklet_cnt;

    ts_pair_scheduler dut (
        .clk             (clk),
        .res             (res),
        .start_proc      (start_proc),
        .stub_adr_ld_en  (stub_adr_ld_en),
        .stub_cntr_ld_en (stub_cntr_ld_en),
        .inner_base      (inner_base),
        .outer_base      (outer_base),
        .inner_cnt       (inner_cnt),
        .outer_cnt       (outer_cnt),
        .pipe_stall      (pipe_stall),
        .tracklet_found  (tracklet_found),
        .tracklet_cnt_clr(tracklet_cnt_clr),
        .inner_rd_adr    (inner_rd_adr),
        .outer_rd_adr    (outer_rd_adr),
        .rd_en           (rd_en),
        .pair_vld        (pair_vld),
        .last_pair       (last_pair),
        .proc_sm_bsy     (proc_sm_bsy),
        .proc_done       (proc_done),
        .tracklet_cnt    (tracklet_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] ia;
        logic [5:0] oa;
        logic       last;
    } pair_t;

    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    pair_t iss_q[$];
    logic  dl_vld[LAT];
    logic  dl_last[LAT];
    int    trk_m;
    bit    xing_active;
    bit    done_seen;
    bit    bsy_low_chk;
    int    start_cyc;
    int    exp_lat;
    int    exp_pairs;
    int    pv_cnt;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // tracklet count model: clear beats found, saturate at 4095
    always @(posedge clk) begin
        if (res || tracklet_cnt_clr) trk_m = 0;
        else if (tracklet_found && trk_m < 4095) trk_m++;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        pair_t e;
        check("trk_cnt", 32'(tracklet_cnt), 32'(trk_m));
        if (res) begin
            iss_q.delete();
            for (int k = 0; k < LAT; k++) begin
                dl_vld[k]  = 1'b0;
                dl_last[k] = 1'b0;
            end
            xing_active = 1'b0;
            bsy_low_chk = 1'b0;
        end else begin
            if (pair_vld || dl_vld[LAT-1]) begin
                check("pair_vld", 32'(pair_vld), 32'(dl_vld[LAT-1]));
                if (pair_vld && dl_vld[LAT-1])
                    check("last_pair", 32'(last_pair), 32'(dl_last[LAT-1]));
            end
            if (pair_vld) pv_cnt++;
            for (int k = LAT - 1; k > 0; k--) begin
                dl_vld[k]  = dl_vld[k-1];
                dl_last[k] = dl_last[k-1];
            end
            dl_vld[0]  = rd_en;
            dl_last[0] = 1'b0;
            if (rd_en) begin
                if (iss_q.size() == 0) begin
                    check("spurious_rd", 32'(rd_en), 32'(0));
                end else begin
                    e = iss_q.pop_front();
                    check("inner_adr", 32'(inner_rd_adr), 32'(e.ia));
                    check("outer_adr", 32'(outer_rd_adr), 32'(e.oa));
                    dl_last[0] = e.last;
                end
            end
            if (proc_done) begin
                if (!xing_active) begin
                    check("unexpected_done", 32'(proc_done), 32'(0));
                end else begin
                    check("pairs_left", 32'(iss_q.size()), 32'(0));
                    check("pair_count", 32'(pv_cnt), 32'(exp_pairs));
                    check("bsy_at_done", 32'(proc_sm_bsy), 32'(1));
                    if (exp_lat >= 0)
                        check("done_latency", 32'(cyc - start_cyc),
                              32'(exp_lat));
                    xing_active = 1'b0;
                    done_seen   = 1'b1;
                    bsy_low_chk = 1'b1;
                end
            end else if (bsy_low_chk) begin
                check("bsy_low", 32'(proc_sm_bsy), 32'(0));
                bsy_low_chk = 1'b0;
            end
        end
    end

    task automatic begin_xing(input int ib, input int ob,
                              input int n, input int m, input int mode);
        @(posedge clk);
        #1;
        start_proc      = 1'b1;
        stub_adr_ld_en  = 1'b1;
        stub_cntr_ld_en = 1'b1;
        inner_base      = 6'(ib);
        outer_base      = 6'(ob);
        inner_cnt       = 7'(n);
        outer_cnt       = 7'(m);
        start_cyc       = cyc;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < m; j++)
                iss_q.push_back('{ia: 6'(ib + i), oa: 6'(ob + j),
                                  last: (i == n - 1) && (j == m - 1)});
        exp_pairs   = n * m;
        exp_lat     = (mode != 0) ? -1 : ((n * m == 0) ? 2 : n * m + 3 + LAT);
        pv_cnt      = 0;
        done_seen   = 1'b0;
        xing_active = 1'b1;
    endtask

    // mode 0: no stall, 1: random stall + ignored start, 2: 4-cycle stall
    task automatic run_xing(input int ib, input int ob,
                            input int n, input int m, input int mode);
        int k;
        begin_xing(ib, ob, n, m, mode);
        k = 0;
        while (!done_seen && k < 3000) begin
            @(posedge clk);
            #1;
            start_proc      = 1'b0;
            stub_adr_ld_en  = 1'b0;
            stub_cntr_ld_en = 1'b0;
            pipe_stall      = 1'b0;
            if (mode == 1) begin
                pipe_stall       = ($urandom_range(0, 3) == 0);
                tracklet_found   = ($urandom_range(0, 2) == 0);
                tracklet_cnt_clr = ($urandom_range(0, 15) == 0);
                if (k == 3) begin
                    start_proc      = 1'b1;
                    stub_adr_ld_en  = 1'b1;
                    stub_cntr_ld_en = 1'b1;
                    inner_base      = 6'($urandom);
                    inner_cnt       = 7'($urandom_range(1, 9));
                end
            end else if (mode == 2) begin
                pipe_stall = (k >= 4 && k <= 7);
            end
            k++;
        end
        if (!done_seen) begin
            check("done_timeout", 32'(done_seen), 32'(1));
            xing_active = 1'b0;
        end
        pipe_stall       = 1'b0;
        start_proc       = 1'b0;
        tracklet_found   = 1'b0;
        tracklet_cnt_clr = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        res              = 1'b1;
        start_proc       = 1'b0;
        stub_adr_ld_en   = 1'b0;
        stub_cntr_ld_en  = 1'b0;
        inner_base       = '0;
        outer_base       = '0;
        inner_cnt        = '0;
        outer_cnt        = '0;
        pipe_stall       = 1'b0;
        tracklet_found   = 1'b0;
        tracklet_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        check("reset_state",
              32'({inner_rd_adr, outer_rd_adr, rd_en, pair_vld, last_pair,
                   proc_sm_bsy, proc_done, tracklet_cnt}), 32'(0));

        run_xing(8'h10, 8'h20, 2, 3, 0);
        run_xing(8'h05, 8'h07, 0, 5, 0);
        run_xing(8'h01, 8'h30, 3, 3, 2);
        run_xing(8'h3E, 8'h11, 4, 1, 0);
        run_xing(8'h3F, 8'h3D, 1, 1, 0);

        for (int r = 0; r < 12; r++)
            run_xing(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 1)));

        // tracklet counter: five pulses, then clear wins over found
        @(posedge clk);
        #1;
        tracklet_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        tracklet_cnt_clr = 1'b0;
        tracklet_found   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tracklet_found = 1'b0;
        @(negedge clk);
        check("trk_five", 32'(tracklet_cnt), 32'(5));
        @(posedge clk);
        #1;
        tracklet_found   = 1'b1;
        tracklet_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        tracklet_found   = 1'b0;
        tracklet_cnt_clr = 1'b0;
        @(negedge clk);
        check("trk_clr_wins", 32'(tracklet_cnt), 32'(0));

        // saturation
        @(posedge clk);
        #1;
        tracklet_found = 1'b1;
        repeat (4100) @(posedge clk);
        #1;
        @(negedge clk);
        check("trk_saturate", 32'(tracklet_cnt), 32'(12'hFFF));
        @(posedge clk);
        #1;
        tracklet_found = 1'b0;
        @(negedge clk);
        check("trk_hold", 32'(tracklet_cnt), 32'(12'hFFF));

        // reset mid-ISSUE of a 4x4 crossing
        begin_xing(8'h08, 8'h18, 4, 4, 0);
        repeat (6) begin
            @(posedge clk);
            #1;
            start_proc      = 1'b0;
            stub_adr_ld_en  = 1'b0;
            stub_cntr_ld_en = 1'b0;
        end
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        check("abort_outputs",
              32'({inner_rd_adr, outer_rd_adr, rd_en, pair_vld, last_pair,
                   proc_sm_bsy, proc_done, tracklet_cnt}), 32'(0));
        run_xing(8'h08, 8'h18, 4, 4, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
